// File: rtl/ch_serializer.sv
// Buffers wide pixel vectors in a small FIFO and emits each one as CH_NUM/LANES narrow beats.
// Optional frame-end marking (dout_last plus a pixel counter) is enabled by CH_SERIALIZER_LAST_EN.
module ch_serializer #(
  parameter int CH_NUM     = 128,
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int PIX_MAX    = 50176
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [$clog2(PIX_MAX):0]              pix_num,
  input  logic                                  fin_start,
  input  logic                                  din_vld,
  input  logic [CH_NUM*DATA_WIDTH-1:0]          din,
  input  logic                                  dout_rdy,
  output logic                                  dout_vld,
  output logic [LANES*DATA_WIDTH-1:0]           dout,
  output logic [$clog2(CH_NUM/LANES):0]         beat_idx,
  output logic                                  fout_start,
  output logic                                  overflow
`ifdef CH_SERIALIZER_LAST_EN
  ,
  output logic                                  dout_last
`endif
);

  localparam int BEATS = CH_NUM / LANES;
  localparam int BW    = $clog2(BEATS) + 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int OW    = AW + 1;
  localparam int PW    = LANES * DATA_WIDTH;

  logic [CH_NUM*DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic                         tag_mem [FIFO_DEPTH];

  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt, ld_ptr;
  logic [OW-1:0] count;
  logic          pending;
  logic          full, last_beat, xfer, pop, push;
  logic          load, ld_tag;
  logic [BW-1:0] ld_beat;
  logic [PW-1:0] ld_dat;

  assign full      = (count == OW'(FIFO_DEPTH));
  assign last_beat = (beat_idx == BW'(BEATS - 1));
  assign xfer      = dout_vld && dout_rdy;
  assign pop       = xfer && last_beat;
  // A final-beat pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign push      = din_vld && (!full || pop);
  assign rd_nxt    = rd_ptr + AW'(1);

  // The output register holds one beat; it reloads whenever it is empty or its beat transfers.
  always_comb begin
    load    = 1'b0;
    ld_ptr  = rd_ptr;
    ld_beat = '0;
    if (xfer && !last_beat) begin
      load    = 1'b1;
      ld_beat = beat_idx + BW'(1);
    end else if (pop) begin
      load   = (count > OW'(1));
      ld_ptr = rd_nxt;
    end else if (!dout_vld) begin
      load = (count != '0);
    end
  end

  assign ld_dat = mem[ld_ptr][int'(ld_beat)*PW +: PW];
  assign ld_tag = tag_mem[ld_ptr] && (ld_beat == '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr]     <= din;
      tag_mem[wr_ptr] <= fin_start || pending;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      pending    <= 1'b0;
      overflow   <= 1'b0;
      dout_vld   <= 1'b0;
      dout       <= '0;
      beat_idx   <= '0;
      fout_start <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_nxt;
      count <= count + OW'(push) - OW'(pop);
      // A dropped tagged pixel leaves its start pending for the next accepted one.
      if (push)           pending <= 1'b0;
      else if (fin_start) pending <= 1'b1;
      if (din_vld && !push) overflow <= 1'b1;
      if (load) begin
        dout_vld   <= 1'b1;
        dout       <= ld_dat;
        beat_idx   <= ld_beat;
        fout_start <= ld_tag;
      end else if (xfer) begin
        dout_vld   <= 1'b0;
        beat_idx   <= '0;
        fout_start <= 1'b0;
      end
    end
  end

`ifdef CH_SERIALIZER_LAST_EN
  localparam int NW = $clog2(PIX_MAX) + 1;
  logic [NW-1:0] pix_cnt, ld_idx;

  // Frame position of the pixel whose beat is being loaded.
  always_comb begin
    ld_idx = pix_cnt;
    if (ld_tag)   ld_idx = '0;
    else if (pop) ld_idx = pix_cnt + NW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_cnt   <= '0;
      dout_last <= 1'b0;
    end else begin
      if (load && ld_tag) pix_cnt <= '0;
      else if (pop)       pix_cnt <= pix_cnt + NW'(1);
      if (load)      dout_last <= (ld_beat == BW'(BEATS - 1)) && (ld_idx == pix_num - NW'(1));
      else if (xfer) dout_last <= 1'b0;
    end
  end
`else
  logic unused_pix_num;
  assign unused_pix_num = ^pix_num;
`endif

endmodule

// File: tb/tb_ch_serializer.sv
// Scoreboard bench for ch_serializer: stimulus queues expected beats, a negedge monitor checks them.
module tb_ch_serializer;
  localparam int CH_NUM  = 128;
  localparam int DW      = 8;
  localparam int LANES   = 16;
  localparam int BEATS   = 8;
  localparam int FD      = 4;
  localparam int PIX_MAX = 50176;
  localparam int NW      = $clog2(PIX_MAX) + 1;

  typedef struct packed {
    logic [LANES*DW-1:0] dat;
    logic [3:0]          idx;
    logic                st;
    logic                last;
  } beat_t;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [NW-1:0]          pix_num;
  logic                   fin_start, din_vld, dout_rdy;
  logic [CH_NUM*DW-1:0]   din;
  logic                   dout_vld;
  logic [LANES*DW-1:0]    dout;
  logic [3:0]             beat_idx;
  logic                   fout_start, overflow, dl;
`ifdef CH_SERIALIZER_LAST_EN
  logic                   dout_last;
  assign dl = dout_last;
`else
  assign dl = 1'b0;
`endif

  beat_t exp_q[$];
  beat_t h;
  logic  hold_pend = 1'b0;
  int    n_chk = 0, n_fail = 0, xfer_cnt = 0;

  always #5 clk = ~clk;

  ch_serializer #(
    .CH_NUM(CH_NUM), .DATA_WIDTH(DW), .LANES(LANES), .FIFO_DEPTH(FD), .PIX_MAX(PIX_MAX)
  ) dut (
    .clk(clk), .reset(reset), .pix_num(pix_num), .fin_start(fin_start),
    .din_vld(din_vld), .din(din), .dout_rdy(dout_rdy), .dout_vld(dout_vld),
    .dout(dout), .beat_idx(beat_idx), .fout_start(fout_start), .overflow(overflow)
`ifdef CH_SERIALIZER_LAST_EN
    , .dout_last(dout_last)
`endif
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Pixel "base": channel k carries base+k, so beat i lane j must carry base+16i+j.
  task automatic push_pix(input logic [7:0] base, input logic fin, input logic exp_tag,
                          input logic accept, input logic lastp);
    beat_t e;
    for (int k = 0; k < CH_NUM; k++) din[k*DW +: DW] = 8'(int'(base) + k);
    if (accept) begin
      for (int i = 0; i < BEATS; i++) begin
        for (int j = 0; j < LANES; j++) e.dat[j*DW +: DW] = 8'(int'(base) + 16*i + j);
        e.idx  = 4'(i);
        e.st   = exp_tag && (i == 0);
        e.last = lastp && (i == BEATS - 1);
        exp_q.push_back(e);
      end
    end
    din_vld   = 1'b1;
    fin_start = fin;
    @(posedge clk); #1;
    din_vld   = 1'b0;
    fin_start = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(posedge clk);
      c++;
    end
    @(posedge clk); #1;
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_vld"}, dout_vld, 0);
    check({tag, "_dout"}, dout, 0);
    check({tag, "_idx"}, beat_idx, 0);
    check({tag, "_fstart"}, fout_start, 0);
    check({tag, "_last"}, dl, 0);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend)
        check("hold", {dout_vld, dout, beat_idx, fout_start, dl}, {1'b1, h});
      hold_pend = dout_vld && !dout_rdy;
      h.dat = dout; h.idx = beat_idx; h.st = fout_start; h.last = dl;
      if (dout_vld && dout_rdy) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL beat: unexpected beat idx=%0d dout=%0h, none required", beat_idx, dout);
        end else begin
          check("beat", {dout, beat_idx, fout_start, dl}, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #60000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int   c0;
    logic found;
    din = '0; din_vld = 0; fin_start = 0; dout_rdy = 1; pix_num = NW'(1000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("rst");
    check("rst_ovf", overflow, 0);
    @(posedge clk); #1 reset = 0;
    @(posedge clk); #1;

    // basic: one-clock latency, fout_start on beat 0 only
    push_pix(8'h00, 1, 1, 1, 0);
    check("lat_n_vld", dout_vld, 0);
    @(posedge clk); #1;
    check("lat_n1_vld", dout_vld, 1);
    check("lat_n1_idx", beat_idx, 0);
    check("lat_n1_fstart", fout_start, 1);
    drain("basic_drain", 40);

    // two back-to-back pixels must stream 16 beats without a bubble
    c0 = xfer_cnt;
    push_pix(8'h40, 0, 0, 1, 0);
    push_pix(8'h80, 0, 0, 1, 0);
    repeat (16) @(posedge clk); #1;
    check("tput_cnt", xfer_cnt - c0, 16);
    check("tput_idle", dout_vld, 0);
    drain("tput_drain", 40);

    // backpressure 1,0,0 pattern
    fork
      begin
        for (int c = 0; c < 60; c++) begin
          dout_rdy = (c % 3 == 0);
          @(posedge clk); #1;
        end
        dout_rdy = 1;
      end
      begin
        push_pix(8'h11, 1, 1, 1, 0);
        push_pix(8'h22, 0, 0, 1, 0);
      end
    join
    drain("bp_drain", 100);
    check("bp_ovf", overflow, 0);

    // overflow: 4 fit, tagged 5th dropped, its start carried to the next push
    dout_rdy = 0;
    push_pix(8'h10, 1, 1, 1, 0);
    push_pix(8'h20, 0, 0, 1, 0);
    push_pix(8'h30, 0, 0, 1, 0);
    push_pix(8'h40, 0, 0, 1, 0);
    check("ovf_before", overflow, 0);
    push_pix(8'h50, 1, 0, 0, 0);
    check("ovf_set", overflow, 1);
    dout_rdy = 1;
    drain("ovf_drain", 100);
    check("ovf_sticky", overflow, 1);
    push_pix(8'h60, 0, 1, 1, 0);
    drain("pend_drain", 40);
    check("ovf_sticky2", overflow, 1);

    reset = 1;
    @(posedge clk); @(negedge clk);
    check("rst2_ovf", overflow, 0);
    @(posedge clk); #1 reset = 0;
    @(posedge clk); #1;
    check("ovf_cleared", overflow, 0);

    // full FIFO with push on the final-beat transfer
    dout_rdy = 0;
    push_pix(8'h70, 1, 1, 1, 0);
    push_pix(8'h78, 0, 0, 1, 0);
    push_pix(8'h80, 0, 0, 1, 0);
    push_pix(8'h88, 0, 0, 1, 0);
    dout_rdy = 1;
    repeat (7) @(posedge clk); #1;
    check("fullpop_idx", beat_idx, 7);
    push_pix(8'h90, 0, 0, 1, 0);
    check("fullpop_ovf", overflow, 0);
    drain("fullpop_drain", 100);
    check("fullpop_ovf2", overflow, 0);

    // reset during beat 3 of pixel 2
    push_pix(8'hA0, 1, 1, 1, 0);
    push_pix(8'hB0, 0, 0, 1, 0);
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (dout_vld && beat_idx == 4'd3 && dout[7:0] == 8'hE0) found = 1;
    end
    check("mid_found", found, 1);
    #2 reset = 1;
    #1 check_zero("midrst");
    exp_q.delete();
    @(posedge clk); @(posedge clk); #1 reset = 0;
    repeat (3) @(posedge clk); #1;
    check("post_rst_idle", dout_vld, 0);
    push_pix(8'hC0, 1, 1, 1, 0);
    push_pix(8'hD0, 0, 0, 1, 0);
    drain("post_rst_drain", 60);

`ifdef CH_SERIALIZER_LAST_EN
    // frame end: last on 4th pixel; early restart has no last; next frame counts from 0
    pix_num = NW'(4);
    push_pix(8'h01, 1, 1, 1, 0);
    push_pix(8'h02, 0, 0, 1, 0);
    push_pix(8'h03, 0, 0, 1, 0);
    push_pix(8'h04, 0, 0, 1, 1);
    drain("last_f1", 60);
    push_pix(8'h05, 1, 1, 1, 0);
    push_pix(8'h06, 0, 0, 1, 0);
    push_pix(8'h07, 1, 1, 1, 0);
    push_pix(8'h08, 0, 0, 1, 0);
    push_pix(8'h09, 0, 0, 1, 0);
    push_pix(8'h0A, 0, 0, 1, 1);
    drain("last_f2", 100);
`endif

    check("final_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
